// File: rtl/factorial_engine.sv
// Iterative n! unit: start/done handshake, one multiply per cycle, sticky overflow.
// Optional FACTORIAL_OVF_ABORT_EN: saturate result and stop on the first overflowing multiply.
module factorial_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IN_W-1:0]   n,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  localparam int unsigned PROD_W = DATA_W + IN_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                overflow_q, overflow_d;
  logic [PROD_W-1:0]   prod;
  logic                prod_ovf;

  // Full-width product; anything above DATA_W means the true value no longer fits
  always_comb begin
    prod     = PROD_W'(acc_q) * PROD_W'(cnt_q);
    prod_ovf = |prod[PROD_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    result_d   = result_q;
    overflow_d = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d      = n;
          acc_d      = DATA_W'(1);
          overflow_d = 1'b0;
          state_d    = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q <= IN_W'(1)) begin
          result_d = acc_q;
          state_d  = ST_DONE;
        end else begin
`ifdef FACTORIAL_OVF_ABORT_EN
          if (prod_ovf) begin
            result_d   = '1;
            overflow_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            acc_d = prod[DATA_W-1:0];
            cnt_d = cnt_q - IN_W'(1);
          end
`else
          acc_d = prod[DATA_W-1:0];
          cnt_d = cnt_q - IN_W'(1);
          if (prod_ovf) begin
            overflow_d = 1'b1;
          end
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready    = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_CALC);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_factorial_engine.sv
// Bench for factorial_engine: directed and random operands against an arithmetic n! model.
// Honours FACTORIAL_OVF_ABORT_EN the same way as the design.
module tb_factorial_engine;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IN_W   = 8;
  localparam int unsigned MAX_EDGES = 400;

  logic              clk;
  logic              rst;
  logic              start;
  logic [IN_W-1:0]   n;
  logic              ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              overflow;

  int total;
  int bad;

  factorial_engine #(.DATA_W(DATA_W), .IN_W(IN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n        (n),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: walk n, n-1, ..., 2 with exact arithmetic while it fits, modular result throughout
  task automatic model(input int unsigned nv, output logic [DATA_W-1:0] res,
                       output bit ovf, output int unsigned lat);
    longint unsigned exact;
    longint unsigned modp;
    int unsigned     steps;
    bit              aborted;
    exact   = 1;
    modp    = 1;
    ovf     = 1'b0;
    aborted = 1'b0;
    steps   = 0;
    for (int unsigned k = nv; k >= 2; k--) begin
      steps++;
      if (!ovf) begin
        exact = exact * longint'(k);
        if (exact > 64'h0000_0000_FFFF_FFFF) ovf = 1'b1;
      end
      modp = (modp * longint'(k)) & 64'h0000_0000_FFFF_FFFF;
`ifdef FACTORIAL_OVF_ABORT_EN
      if (ovf) begin
        aborted = 1'b1;
        break;
      end
`endif
    end
    if (aborted) begin
      res = '1;
      lat = steps + 1;
    end else begin
      res = DATA_W'(modp);
      lat = ((nv > 1) ? nv : 1) + 1;
    end
  endtask

  // One operation; poke drives random start/n while the engine is busy and in DONE
  task automatic run_op(input int unsigned nv, input bit poke);
    logic [DATA_W-1:0] exp_res;
    bit                exp_ovf;
    int unsigned       exp_lat;
    int unsigned       edges;
    model(nv, exp_res, exp_ovf, exp_lat);
    @(negedge clk);
    chk("ready_before_start", ready, 1);
    start = 1'b1;
    n     = IN_W'(nv);
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    chk("busy_after_accept", busy, 1);
    chk("ready_after_accept", ready, 0);
    while (!done && edges < MAX_EDGES) begin
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        n     = IN_W'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    chk($sformatf("latency_n%0d", nv), 64'(edges), 64'(exp_lat));
    chk($sformatf("result_n%0d", nv), result, exp_res);
    chk($sformatf("overflow_n%0d", nv), overflow, exp_ovf);
    if (poke) begin
      start = 1'b1;
      n     = IN_W'(3);
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_after_done", ready, 1);
    chk("done_single_pulse", done, 0);
    chk("result_held", result, exp_res);
    chk("overflow_held", overflow, exp_ovf);
  endtask

  initial begin
    int unsigned gap;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    n     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op(5, 1'b0);
    run_op(0, 1'b0);
    run_op(1, 1'b0);
    run_op(12, 1'b0);
    run_op(13, 1'b0);
    run_op(15, 1'b0);
    run_op(10, 1'b1);

    // Reset in the middle of a calculation
    @(negedge clk);
    start = 1'b1;
    n     = IN_W'(9);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_ready", ready, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_result", result, 0);
    chk("midreset_overflow", overflow, 0);
    run_op(4, 1'b0);

    for (int i = 0; i < 30; i++) begin
      if ((i % 5) == 4) run_op($urandom_range(0, 255), 1'b1);
      else              run_op($urandom_range(0, 20), i[0]);
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      #1;
      chk("idle_stays_ready", ready, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
